// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and the decode/hazard logic.
// master = environment side (memory + decode), slave = fetch_queue.
interface fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic [31:0]    imem_addr;
  logic [31:0]    imem_rd;
  logic           stall;
  logic           redirect;
  logic [31:0]    redirect_pc;
  logic           valid_out;
  logic [31:0]    instr_out;
  logic [31:0]    pc_incr_out;
  logic [PTR_W:0] count;

  modport master (
    output imem_rd, stall, redirect, redirect_pc,
    input  imem_addr, valid_out, instr_out, pc_incr_out, count
  );

  modport slave (
    input  imem_rd, stall, redirect, redirect_pc,
    output imem_addr, valid_out, instr_out, pc_incr_out, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: private fetch PC feeding a DEPTH-entry {instr, pc+4} FIFO.
// Optional FQ_JUMP_PREDECODE_EN: follow j targets at fetch time and absorb the matching decode redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.slave   bus
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      fpc_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc4_mem   [DEPTH];

  logic        valid;
  logic        flush;
  logic        pop;
  logic        push;
  logic [31:0] fpc_plus4;
  logic [31:0] fpc_next;
  logic [31:0] redirect_target;

  assign fpc_plus4       = fpc_reg + 32'd4;
  assign redirect_target = bus.redirect_pc & ~32'h3;
  assign valid           = (count_reg != '0);

`ifdef FQ_JUMP_PREDECODE_EN
  logic        jflag_mem [DEPTH];
  logic [31:0] jtgt_mem  [DEPTH];
  logic        is_j;
  logic [31:0] j_target;
  logic        jpd_hit_reg;

  assign is_j     = (bus.imem_rd[31:26] == 6'b000010);
  assign j_target = {fpc_plus4[31:28], bus.imem_rd[25:0], 2'b00};
  assign fpc_next = is_j ? j_target : fpc_plus4;
  // Decode's late redirect for a j we already followed must not flush the correct-path words behind it.
  assign flush    = bus.redirect &
                    ~(valid & jflag_mem[head_reg] & (jtgt_mem[head_reg] == redirect_target));

  always_ff @(posedge clk) begin
    if (push) begin
      jflag_mem[tail_reg] <= is_j;
      jtgt_mem[tail_reg]  <= j_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) jpd_hit_reg <= 1'b0;
    else     jpd_hit_reg <= push & is_j;
  end
`else
  assign fpc_next = fpc_plus4;
  assign flush    = bus.redirect;
`endif

  assign pop  = valid & ~bus.stall & ~flush;
  assign push = ~flush & ((count_reg < FULL) | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_reg] <= bus.imem_rd;
      pc4_mem[tail_reg]   <= fpc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_reg   <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      fpc_reg   <= redirect_target;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
        fpc_reg  <= fpc_next;
      end
      if (pop)
        head_reg <= head_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
    end
  end

  // An empty queue presents zeros so decode sees a NOP bubble.
  assign bus.imem_addr   = fpc_reg;
  assign bus.valid_out   = valid;
  assign bus.instr_out   = valid ? instr_mem[head_reg] : 32'h0;
  assign bus.pc_incr_out = valid ? pc4_mem[head_reg]   : 32'h0;
  assign bus.count       = count_reg;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized stall/redirect
// traffic checked against a queue-based reference model.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [31:0] mem [64];
  logic [63:0] mq [$];          // {instr, pc+4} expected queue contents
  logic [31:0] mfpc;

  fetch_queue_if #(.PTR_W(2)) bus ();

  fetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rd = mem[bus.imem_addr[7:2]];

  task automatic model_reset();
    mq.delete();
    mfpc = 32'h0;
  endtask

  // Advance the reference model by one clock using the spec rules, then cross the edge.
  task automatic tick();
    int          n;
    bit          do_pop, do_push, eff_redirect;
    logic [31:0] w, nxt, hi, hp;
    n = mq.size();
    eff_redirect = bus.redirect;
`ifdef FQ_JUMP_PREDECODE_EN
    if (bus.redirect && n > 0) begin
      hi = mq[0][63:32];
      hp = mq[0][31:0];
      if (hi[31:26] == 6'b000010 &&
          {hp[31:28], hi[25:0], 2'b00} == (bus.redirect_pc & ~32'h3))
        eff_redirect = 1'b0;
    end
`else
    hi = 32'h0;
    hp = 32'h0;
`endif
    do_pop  = (n > 0) && !bus.stall && !eff_redirect;
    do_push = !eff_redirect && ((n < 4) || do_pop);
    w = mem[mfpc[7:2]];
    nxt = mfpc + 32'd4;
`ifdef FQ_JUMP_PREDECODE_EN
    if (w[31:26] == 6'b000010) nxt = {nxt[31:28], w[25:0], 2'b00};
`endif
    if (eff_redirect) begin
      mq.delete();
      mfpc = bus.redirect_pc & ~32'h3;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({w, mfpc + 32'd4});
        mfpc = nxt;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d stall=%0b redir=%0b addr=%h valid=%0b instr=%h pc4=%h count=%0d",
             cyc, bus.stall, bus.redirect, bus.imem_addr, bus.valid_out,
             bus.instr_out, bus.pc_incr_out, bus.count);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.valid_out !== 1'b0 || bus.count !== 3'd0 || bus.imem_addr !== 32'h0 ||
        bus.instr_out !== 32'h0 || bus.pc_incr_out !== 32'h0) begin
      errors++;
      $display("FAIL reset: valid=%0b count=%0d addr=%h instr=%h pc4=%h, required 0,0,0,0,0",
               bus.valid_out, bus.count, bus.imem_addr, bus.instr_out, bus.pc_incr_out);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.instr_out !== 32'h20080001 || bus.pc_incr_out !== 32'h4) begin
      errors++;
      $display("FAIL seq_cycle1: valid=%0b instr=%h pc4=%h, required 1 20080001 00000004",
               bus.valid_out, bus.instr_out, bus.pc_incr_out);
    end
    tick();
    checks++;
    if (bus.instr_out !== 32'h20090002 || bus.pc_incr_out !== 32'h8) begin
      errors++;
      $display("FAIL seq_cycle2: instr=%h pc4=%h, required 20090002 00000008",
               bus.instr_out, bus.pc_incr_out);
    end
  endtask

  task automatic test_stall_fill();
    logic [2:0] exp_cnt;
    apply_reset();
    bus.stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_cnt = (i < 3) ? 3'(i + 1) : 3'd4;
      checks++;
      if (bus.count !== exp_cnt) begin
        errors++;
        $display("FAIL stall_count[%0d]: got %0d required %0d", i, bus.count, exp_cnt);
      end
    end
    checks++;
    if (bus.imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_addr_hold: got %h required 00000010", bus.imem_addr);
    end
    bus.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.pc_incr_out !== 32'(4 * (k + 1)) || bus.count !== 3'd4) begin
        errors++;
        $display("FAIL drain_head[%0d]: pc4=%h count=%0d required %h 4",
                 k, bus.pc_incr_out, bus.count, 32'(4 * (k + 1)));
      end
      tick();
    end
  endtask

  task automatic test_full_stream();
    logic [31:0] prev_addr;
    bus.stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prev_addr = bus.imem_addr;
      tick();
      checks++;
      if (bus.count !== 3'd4 || bus.imem_addr !== prev_addr + 32'd4 ||
          bus.instr_out !== mq[0][63:32] || bus.pc_incr_out !== mq[0][31:0]) begin
        errors++;
        $display("FAIL full_stream[%0d]: count=%0d addr=%h instr=%h pc4=%h required 4 %h %h %h",
                 i, bus.count, bus.imem_addr, bus.instr_out, bus.pc_incr_out,
                 prev_addr + 32'd4, mq[0][63:32], mq[0][31:0]);
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    bus.stall = 1'b1;
    repeat (3) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h42;   // low bits must be dropped
    tick();
    bus.redirect = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.valid_out !== 1'b0 || bus.imem_addr !== 32'h40 ||
        bus.instr_out !== 32'h0) begin
      errors++;
      $display("FAIL redirect_flush: count=%0d valid=%0b addr=%h instr=%h required 0 0 00000040 0",
               bus.count, bus.valid_out, bus.imem_addr, bus.instr_out);
    end
    tick();
    checks++;
    if (bus.instr_out !== mem[16] || bus.pc_incr_out !== 32'h44 || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL redirect_target: instr=%h pc4=%h required %h 00000044",
               bus.instr_out, bus.pc_incr_out, mem[16]);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFFFFF8;
    tick();
    bus.redirect = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.imem_addr !== 32'h0 || bus.pc_incr_out !== 32'h0 || bus.instr_out !== mem[63]) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h pc4=%h instr=%h required 00000000 00000000 %h",
               bus.imem_addr, bus.pc_incr_out, bus.instr_out, mem[63]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.stall = 1'b1;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.count !== 3'd0 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b count=%0d addr=%h required 0 0 00000000",
               bus.valid_out, bus.count, bus.imem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.stall = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      bus.stall = ($urandom_range(0, 1) == 1);
      bus.redirect = ($urandom_range(0, 9) == 0);
      bus.redirect_pc = $urandom & 32'hFF;
      tick();
      checks++;
      if (bus.count !== 3'(mq.size()) || bus.imem_addr !== mfpc ||
          bus.valid_out !== (mq.size() != 0) ||
          bus.instr_out !== ((mq.size() != 0) ? mq[0][63:32] : 32'h0) ||
          bus.pc_incr_out !== ((mq.size() != 0) ? mq[0][31:0] : 32'h0)) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d addr=%h instr=%h pc4=%h required count=%0d addr=%h",
                 i, bus.count, bus.imem_addr, bus.instr_out, bus.pc_incr_out, mq.size(), mfpc);
      end
    end
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
  endtask

`ifdef FQ_JUMP_PREDECODE_EN
  task automatic test_jump_predecode();
    logic [2:0] cnt_before;
    mem[2] = 32'h08000010;
    apply_reset();
    bus.stall = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL jpd_target: addr=%h required 00000040", bus.imem_addr);
    end
    bus.stall = 1'b0;
    repeat (2) tick();
    cnt_before = bus.count;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    checks++;
    if (bus.count !== cnt_before || bus.count !== 3'(mq.size())) begin
      errors++;
      $display("FAIL jpd_no_flush: count=%0d required %0d", bus.count, cnt_before);
    end
    mem[2] = 32'h20000000 | ($urandom & 32'h03FFFFFF);
  endtask
`endif

  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    for (int i = 0; i < 64; i++)
      mem[i] = 32'h20000000 | ($urandom & 32'h03FFFFFF);
    mem[0] = 32'h20080001;
    mem[1] = 32'h20090002;
    model_reset();

    test_reset();
    test_sequential();
    test_stall_fill();
    test_full_stream();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef FQ_JUMP_PREDECODE_EN
    test_jump_predecode();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
